// File: rtl/ceres_param.sv
// Shared constants for the reset controller: register map, SWRST key,
// CAUSE/CTRL bit positions and the sequencer state encoding.
package ceres_param;

    localparam logic [3:0]  ADR_CAUSE = 4'h0;
    localparam logic [3:0]  ADR_CTRL  = 4'h1;
    localparam logic [3:0]  ADR_SWRST = 4'h2;
    localparam logic [3:0]  ADR_STATE = 4'h3;

    localparam logic [31:0] SWRST_KEY = 32'hA5A5_0001;

    localparam int CAUSE_POR = 0;
    localparam int CAUSE_EXT = 1;
    localparam int CAUSE_WDT = 2;
    localparam int CAUSE_SW  = 3;
    localparam int CAUSE_DBG = 4;
    localparam int CAUSE_W   = 5;

    localparam int CTRL_WDT_EN = 0;
    localparam int CTRL_EXT_EN = 1;
    localparam int CTRL_W      = 2;

    typedef enum logic [1:0] {
        ST_ASSERT     = 2'd0,
        ST_PERIPH_REL = 2'd1,
        ST_RUN        = 2'd2
    } rst_state_e;

    // Bits needed to hold max(a, b) - 1, never less than one.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Multi-flop synchronizer for an asynchronous active-low reset input.
// All flops clear to 0 on rst_ni, so the synchronized output reads "asserted".
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_d[gi] = d_i;
            end else begin : g_chain
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_ctrl.sv
// System reset sequencer: collects reset requests, records their causes and
// releases the peripheral reset first and the CPU reset CPU_DELAY cycles later.
module reset_ctrl
    import ceres_param::*;
#(
    parameter int HOLD_CYCLES = 32,
    parameter int CPU_DELAY   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stb_i,
    input  logic [3:0]  adr_i,
    input  logic [3:0]  byte_sel_i,
    input  logic        we_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        ext_rst_ni,
    input  logic        wdt_rst_i,
    input  logic        dbg_rst_i,
    output logic        periph_rst_no,
    output logic        cpu_rst_no
);

    localparam int              CNT_W     = cnt_width(HOLD_CYCLES, CPU_DELAY);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LOAD  = CNT_W'(CPU_DELAY - 1);

    rst_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CAUSE_W-1:0]       cause_q, cause_d;
    logic [CTRL_W-1:0]        ctrl_q, ctrl_d;
    logic [SYNC_STAGES-1:0]   ext_armed_q, ext_armed_d;
    logic                     periph_q, periph_d;
    logic                     cpu_q, cpu_d;

    logic                     ext_sync;
    logic                     wr_en, rd_en;
    logic                     sw_req, ext_req, wdt_req, dbg_req, req;
    logic [CAUSE_W-1:0]       cause_set, cause_clr;

    rst_sync #(.STAGES(SYNC_STAGES)) u_ext_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (ext_rst_ni),
        .q_o   (ext_sync)
    );

    assign wr_en = stb_i & we_i;
    assign rd_en = stb_i & ~we_i;

    // The synchronizer comes out of power-on reset reading 0; EXT is only
    // trusted once the chain has been refilled, otherwise every POR would
    // also be logged (and lengthened) as a button press.
    assign ext_armed_d = (ext_armed_q << 1) | SYNC_STAGES'(1);
    assign ext_req     = ext_armed_q[SYNC_STAGES-1] & ~ext_sync & ctrl_q[CTRL_EXT_EN];
    assign wdt_req     = wdt_rst_i & ctrl_q[CTRL_WDT_EN];
    assign dbg_req     = dbg_rst_i;
    assign sw_req      = wr_en && (adr_i == ADR_SWRST) && (byte_sel_i == 4'hF)
                         && (dat_i == SWRST_KEY);
    assign req         = ext_req | wdt_req | sw_req | dbg_req;

    always_comb begin
        cause_set            = '0;
        cause_set[CAUSE_EXT] = ext_req;
        cause_set[CAUSE_WDT] = wdt_req;
        cause_set[CAUSE_SW]  = sw_req;
        cause_set[CAUSE_DBG] = dbg_req;
        cause_clr            = '0;
        if (wr_en && (adr_i == ADR_CAUSE) && byte_sel_i[0]) begin
            cause_clr = dat_i[CAUSE_W-1:0];
        end
        cause_d = (cause_q & ~cause_clr) | cause_set;
        ctrl_d  = ctrl_q;
        if (wr_en && (adr_i == ADR_CTRL) && byte_sel_i[0]) begin
            ctrl_d = dat_i[CTRL_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= HOLD_LOAD;
            cause_q     <= CAUSE_W'(1) << CAUSE_POR;
            ctrl_q      <= '1;
            ext_armed_q <= '0;
            periph_q    <= 1'b0;
            cpu_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cause_q     <= cause_d;
            ctrl_q      <= ctrl_d;
            ext_armed_q <= ext_armed_d;
            periph_q    <= periph_d;
            cpu_q       <= cpu_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (req) begin
            state_d = ST_ASSERT;
            cnt_d   = HOLD_LOAD;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_PERIPH_REL;
                        cnt_d   = CPU_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_PERIPH_REL: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = HOLD_LOAD;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register together with it.
    always_comb begin
        periph_d = (state_d != ST_ASSERT);
        cpu_d    = (state_d == ST_RUN);
    end

    assign periph_rst_no = periph_q;
    assign cpu_rst_no    = cpu_q;

    always_comb begin
        dat_o = '0;
        if (rd_en) begin
            case (adr_i)
                ADR_CAUSE: dat_o[CAUSE_W-1:0] = cause_q;
                ADR_CTRL:  dat_o[CTRL_W-1:0]  = ctrl_q;
                ADR_STATE: begin
                    dat_o[1:0]  = state_q;
                    dat_o[15:8] = 8'(cnt_q);
                end
                default:   dat_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_ctrl.sv
// Self-checking bench for reset_ctrl: expectations are queued as stimulus is
// applied and popped when the matching DUT response is sampled.
module tb_reset_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stb_i;
    logic [3:0]  adr_i;
    logic [3:0]  byte_sel_i;
    logic        we_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ext_rst_ni;
    logic        wdt_rst_i;
    logic        dbg_rst_i;
    logic        periph_rst_no;
    logic        cpu_rst_no;

    int tests_run    = 0;
    int tests_failed = 0;

    string       exp_tag_q[$];
    logic [31:0] exp_val_q[$];

    reset_ctrl #(
        .HOLD_CYCLES(32),
        .CPU_DELAY  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .stb_i        (stb_i),
        .adr_i        (adr_i),
        .byte_sel_i   (byte_sel_i),
        .we_i         (we_i),
        .dat_i        (dat_i),
        .dat_o        (dat_o),
        .ext_rst_ni   (ext_rst_ni),
        .wdt_rst_i    (wdt_rst_i),
        .dbg_rst_i    (dbg_rst_i),
        .periph_rst_no(periph_rst_no),
        .cpu_rst_no   (cpu_rst_no)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, obs);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_tag_q.push_back(tag);
        exp_val_q.push_back(val);
    endtask

    task automatic sb_pop_check(input logic [31:0] obs);
        string       tag;
        logic [31:0] val;
        if (exp_val_q.size() == 0) begin
            check_eq("sb_underflow", 32'(exp_val_q.size()), 32'd1);
            return;
        end
        tag = exp_tag_q.pop_front();
        val = exp_val_q.pop_front();
        check_eq(tag, obs, val);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic reg_write(input logic [3:0] adr, input logic [3:0] be, input logic [31:0] data);
        stb_i      = 1'b1;
        we_i       = 1'b1;
        adr_i      = adr;
        byte_sel_i = be;
        dat_i      = data;
        tick(1);
        stb_i      = 1'b0;
        we_i       = 1'b0;
        byte_sel_i = 4'h0;
        dat_i      = '0;
    endtask

    task automatic reg_read(input string tag, input logic [3:0] adr, input logic [31:0] exp);
        sb_push(tag, exp);
        stb_i = 1'b1;
        we_i  = 1'b0;
        adr_i = adr;
        @(negedge clk_i);
        sb_pop_check(dat_o);
        tick(1);
        stb_i = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] exp);
        sb_push(tag, 32'(exp));
        sb_pop_check(32'({periph_rst_no, cpu_rst_no}));
    endtask

    // Counts clock edges until the chosen output goes high; -1 if it never does.
    task automatic measure_release(input string tag, input bit use_cpu, input int exp);
        int n;
        bit seen;
        sb_push(tag, 32'(exp));
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
            seen = use_cpu ? (cpu_rst_no === 1'b1) : (periph_rst_no === 1'b1);
        end
        if (!seen) n = -1;
        sb_pop_check(32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        rst_ni     = 1'b0;
        stb_i      = 1'b0;
        we_i       = 1'b0;
        adr_i      = '0;
        byte_sel_i = '0;
        dat_i      = '0;
        ext_rst_ni = 1'b1;
        wdt_rst_i  = 1'b0;
        dbg_rst_i  = 1'b0;

        // Power-on reset state
        tick(3);
        check_outs("por_outs_low", 2'b00);
        reg_read("por_cause", ADR_CAUSE_TB(), 32'h01);
        reg_read("por_ctrl", 4'h1, 32'h03);
        reg_read("por_state", 4'h3, 32'h0000_1F00);

        rst_ni = 1'b1;
        measure_release("por_periph_cycles", 1'b0, 32);
        measure_release("por_cpu_cycles", 1'b1, 8);
        reg_read("por_cause_after", 4'h0, 32'h01);
        reg_read("run_state", 4'h3, 32'h0000_0002);
        reg_read("swrst_reads_zero", 4'h2, 32'h0);

        // Watchdog pulse of 16 cycles
        wdt_rst_i = 1'b1;
        tick(1);
        check_outs("wdt_outs_low", 2'b00);
        tick(15);
        wdt_rst_i = 1'b0;
        measure_release("wdt_periph_cycles", 1'b0, 32);
        measure_release("wdt_cpu_cycles", 1'b1, 8);
        reg_read("wdt_cause", 4'h0, 32'h05);
        reg_write(4'h0, 4'hE, 32'h05);
        reg_read("cause_w1c_no_be0", 4'h0, 32'h05);
        reg_write(4'h0, 4'h1, 32'h05);
        reg_read("cause_w1c", 4'h0, 32'h00);

        // Software reset key
        reg_write(4'h2, 4'hF, 32'h1234_5678);
        check_outs("sw_badkey_no_reset", 2'b11);
        reg_write(4'h2, 4'h7, 32'hA5A5_0001);
        check_outs("sw_partial_be_no_reset", 2'b11);
        reg_read("sw_badkey_cause", 4'h0, 32'h00);
        reg_write(4'h2, 4'hF, 32'hA5A5_0001);
        check_outs("sw_outs_low", 2'b00);
        measure_release("sw_periph_cycles", 1'b0, 32);
        measure_release("sw_cpu_cycles", 1'b1, 8);
        reg_read("sw_cause", 4'h0, 32'h08);
        reg_write(4'h0, 4'h1, 32'h1F);

        // Enable masking
        reg_write(4'h1, 4'hE, 32'h0);
        reg_read("ctrl_no_be0", 4'h1, 32'h03);
        reg_write(4'h1, 4'h1, 32'h0);
        reg_read("ctrl_cleared", 4'h1, 32'h00);
        wdt_rst_i  = 1'b1;
        ext_rst_ni = 1'b0;
        tick(4);
        wdt_rst_i  = 1'b0;
        ext_rst_ni = 1'b1;
        tick(6);
        check_outs("mask_outs_high", 2'b11);
        reg_read("mask_cause", 4'h0, 32'h00);
        reg_write(4'h1, 4'h1, 32'h3);

        // Debug request landing in PERIPH_REL restarts the full sequence
        dbg_rst_i = 1'b1;
        tick(1);
        dbg_rst_i = 1'b0;
        measure_release("dbg1_periph_cycles", 1'b0, 32);
        tick(3);
        check_outs("dbg_in_periph_rel", 2'b10);
        dbg_rst_i = 1'b1;
        tick(1);
        dbg_rst_i = 1'b0;
        check_outs("dbg_overlap_low", 2'b00);
        measure_release("dbg2_periph_cycles", 1'b0, 32);
        measure_release("dbg2_cpu_cycles", 1'b1, 8);
        reg_read("dbg_cause", 4'h0, 32'h10);
        reg_write(4'h0, 4'h1, 32'h1F);

        // Short asynchronous glitch on the external button
        #3;
        ext_rst_ni = 1'b0;
        #30;
        ext_rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_outs("ext_glitch_low", 2'b00);
        measure_release("ext_periph_cycles", 1'b0, 33);
        measure_release("ext_cpu_cycles", 1'b1, 8);
        reg_read("ext_cause", 4'h0, 32'h02);
        reg_write(4'h0, 4'h1, 32'h1F);

        // Power-on reset in the middle of a sequence
        dbg_rst_i = 1'b1;
        tick(1);
        dbg_rst_i = 1'b0;
        measure_release("abort_pre_periph", 1'b0, 32);
        tick(2);
        #3;
        rst_ni = 1'b0;
        #1;
        check_outs("abort_outs_low", 2'b00);
        reg_read("abort_cause", 4'h0, 32'h01);
        reg_read("abort_state", 4'h3, 32'h0000_1F00);
        rst_ni = 1'b1;
        measure_release("abort_periph_cycles", 1'b0, 32);
        measure_release("abort_cpu_cycles", 1'b1, 8);

        check_eq("sb_leftover", 32'(exp_val_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    function automatic logic [3:0] ADR_CAUSE_TB();
        return 4'h0;
    endfunction

endmodule

// File: doc/reset_ctrl.md
RESET_CTRL -- requirements
Module: reset_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 32: minimum cycles both reset outputs stay asserted after the last active request.
REQ-002 Parameter CPU_DELAY, default 8: cycles between periph_rst_no release and cpu_rst_no release.
REQ-003 Parameter SYNC_STAGES, default 2: flop depth of the ext_rst_ni synchronizer.
REQ-004 Ports, in order:
- clk_i  in  1  system clock; the only clock.
- rst_ni  in  1  power-on reset; asynchronous, active-low.
- stb_i  in  1  register access strobe.
- adr_i  in  4  word address [5:2].
- byte_sel_i  in  4  byte enables.
- we_i  in  1  write enable.
- dat_i  in  32  write data.
- dat_o  out  32  read data.
- ext_rst_ni  in  1  external reset button; asynchronous, active-low.
- wdt_rst_i  in  1  watchdog reset pulse; synchronous to clk_i, active-high.
- dbg_rst_i  in  1  debug-module system reset request; synchronous, active-high.
- periph_rst_no  out  1  peripheral/bus reset; active-low, registered.
- cpu_rst_no  out  1  core reset; active-low, registered.

Function
REQ-005 Register map (word offsets): 0x0 CAUSE, 0x1 CTRL, 0x2 SWRST, 0x3 STATE (read-only).
REQ-006 CAUSE bits: [0] POR, [1] EXT, [2] WDT, [3] SW, [4] DBG; sticky; W1C when byte_sel_i[0] is set; all other bits read 0.
REQ-007 CTRL: [0] WDT_EN and [1] EXT_EN, both reset to 1; a request from a source with its enable at 0 is ignored and not recorded; byte_sel_i[0] gates the write.
REQ-008 SWRST: a full-word write of 0xA5A5_0001 is the SW request; any other value has no effect; reads return 0.
REQ-009 STATE read: [1:0] FSM state encoding, [15:8] current counter value.
REQ-010 dat_o is 0 unless stb_i & ~we_i; the read mux is combinational.
REQ-011 ext_rst_ni passes through a SYNC_STAGES synchronizer (reset value 0); the EXT request is the synchronized value low.
REQ-012 req = (EXT & EXT_EN) | (wdt_rst_i & WDT_EN) | SW | dbg_rst_i.
REQ-013 FSM states: ASSERT, PERIPH_REL, RUN.
REQ-014 ASSERT: both outputs low; counter reloads to HOLD_CYCLES-1 every cycle req=1; otherwise it decrements; at 0 with req=0, move to PERIPH_REL.
REQ-015 PERIPH_REL: periph_rst_no high, cpu_rst_no low; counter runs from CPU_DELAY-1 to 0, then move to RUN.
REQ-016 RUN: both outputs high.
REQ-017 req=1 in any state moves to ASSERT next cycle with counter = HOLD_CYCLES-1; outputs go low one cycle after req is sampled.
REQ-018 Each CAUSE bit is set in every cycle its enabled request is active; set has priority over a W1C in the same cycle.
REQ-019 Simultaneous sources: all active enabled causes are recorded.
REQ-020 A wdt_rst_i pulse longer than HOLD_CYCLES extends ASSERT until HOLD_CYCLES cycles after the pulse ends.
REQ-021 Counter width is $clog2(max(HOLD_CYCLES, CPU_DELAY)); no wrap-around; saturates at 0.

Reset
REQ-022 On rst_ni low: state=ASSERT, counter=HOLD_CYCLES-1, outputs=0, CTRL=0x3, CAUSE=0x01 (POR), synchronizer flops=0.
REQ-023 Only rst_ni resets this block; its own outputs never reset it, so CAUSE survives WDT, SW, EXT and DBG resets.
REQ-024 Mid-sequence rst_ni assertion aborts immediately and re-enters the REQ-022 state.

Structure
REQ-025 Register offsets, the SWRST key value, CAUSE bit indices and the FSM state enum go in ceres_param.
REQ-026 The synchronizer is one sub-module, rst_sync (parameter STAGES), instantiated once for ext_rst_ni.
REQ-027 All state is in one clock domain; there are no derived clocks or latches.

Verification
REQ-028 POR: release rst_ni -> periph_rst_no high at cycle 32 (±1), cpu_rst_no high 8 cycles later, CAUSE=0x01.
REQ-029 WDT: in RUN, drive wdt_rst_i high for 16 cycles -> both outputs low next cycle, periph release 32 cycles after the pulse ends, CAUSE=0x05; then write 0x05 to CAUSE -> reads 0x00.
REQ-030 SW key: write 0x1234_5678 to SWRST -> no reset; write 0xA5A5_0001 -> reset sequence, CAUSE[3]=1.
REQ-031 Masking: CTRL=0x0 with wdt_rst_i and ext_rst_ni pulsed -> outputs stay high, CAUSE unchanged.
REQ-032 Overlap: in PERIPH_REL assert dbg_rst_i for 1 cycle -> ASSERT re-entered, full 32+8 sequence restarts, CAUSE[4]=1.
REQ-033 Glitch: ext_rst_ni low for 3 cycles, asynchronous to clk_i -> EXT recorded after SYNC_STAGES cycles, with no X on the outputs.
